// File: rtl/requant_stream_pkg.sv
// Shared types and constants for the requant_stream output requantizer.
// Optional ReLU clamp is enabled by defining NPU_REQUANT_RELU_EN.
package requant_stream_pkg;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_RUN   = 2'd1,
        REQ_FLUSH = 2'd2
    } req_state_e;

    // Identity config: M = 0.5 in Q31, S = 30, i.e. x * 2^30 / 2^30.
    localparam logic [31:0] REQ_M_RESET = 32'h4000_0000;
    localparam int          REQ_S_RESET = 30;
    localparam int          REQ_S_MAX   = 47;

    localparam int REQ_PROD_W = 48;
    localparam int REQ_R_W    = REQ_PROD_W + 1;
    localparam int REQ_Y_W    = REQ_R_W + 1;
    localparam int REQ_OUT_W  = 8;

    localparam int REQ_SAT_MAX = 127;
    localparam int REQ_SAT_MIN = -128;

    localparam logic signed [REQ_Y_W-1:0] REQ_Y_MAX = REQ_Y_W'(REQ_SAT_MAX);
    localparam logic signed [REQ_Y_W-1:0] REQ_Y_MIN = REQ_Y_W'(REQ_SAT_MIN);

    function automatic logic [REQ_OUT_W-1:0] req_saturate(input logic signed [REQ_Y_W-1:0] y);
        logic [REQ_OUT_W-1:0] res;
        if (y > REQ_Y_MAX) begin
            res = REQ_OUT_W'(REQ_SAT_MAX);
        end else if (y < REQ_Y_MIN) begin
            res = REQ_OUT_W'(REQ_SAT_MIN);
        end else begin
            res = y[REQ_OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/requant_pipe_stage.sv
// One valid/data pipeline register; holds its contents whenever adv is low.
module requant_pipe_stage
    import requant_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/requant_stream.sv
// Three-stage int16 -> int8 requantizer (multiply, round-shift, zero point, saturate).
// Define NPU_REQUANT_RELU_EN to add the cfg_relu input and the y >= Z clamp.
module requant_stream
    import requant_stream_pkg::*;
#(
    parameter int IN_WIDTH           = 16,
    parameter int OUT_WIDTH          = 8,
    parameter int MULT_WIDTH         = 32,
    parameter int SHIFT_WIDTH        = 6,
    parameter int NUM_CHANNELS_WIDTH = 7
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_aresetn,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [MULT_WIDTH-1:0]         cfg_multiplier,
    input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
    input  logic [OUT_WIDTH-1:0]          cfg_zero_point,
`ifdef NPU_REQUANT_RELU_EN
    input  logic                          cfg_relu,
`endif
    input  logic [IN_WIDTH-1:0]           s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [NUM_CHANNELS_WIDTH-1:0] s_axis_tuser,
    output logic [OUT_WIDTH-1:0]          m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [NUM_CHANNELS_WIDTH-1:0] m_axis_tuser,
    output logic                          frame_done,
    output logic [15:0]                   beat_count
);

    localparam int NCW  = NUM_CHANNELS_WIDTH;
    localparam int S1_W = 1 + NCW + REQ_PROD_W;
    localparam int S2_W = 1 + NCW + REQ_R_W;
    localparam int S3_W = 1 + NCW + OUT_WIDTH;

    localparam logic signed [REQ_R_W-1:0] R_ONE = REQ_R_W'(1);

    req_state_e state_q, state_d;

    logic signed [MULT_WIDTH-1:0] mult_q, mult_d;
    logic [SHIFT_WIDTH-1:0]       shift_q, shift_d;
    logic [OUT_WIDTH-1:0]         zp_q, zp_d;
`ifdef NPU_REQUANT_RELU_EN
    logic                         relu_q, relu_d;
`endif

    logic [15:0] count_q, count_d;
    logic        count_clr_q, count_clr_d;

    logic adv, s_hs, m_hs, cfg_load;

    logic            s1_valid, s2_valid, s3_valid;
    logic [S1_W-1:0] s1_in, s1_out;
    logic [S2_W-1:0] s2_in, s2_out;
    logic [S3_W-1:0] s3_in, s3_out;

    logic signed [REQ_PROD_W-1:0] x_ext, m_ext, prod;
    logic                         s1_last;
    logic [NCW-1:0]               s1_user;
    logic signed [REQ_PROD_W-1:0] s1_prod;
    logic signed [REQ_R_W-1:0]    p_ext, rnd, rsum, rshift;
    logic                         s2_last;
    logic [NCW-1:0]               s2_user;
    logic signed [REQ_R_W-1:0]    s2_r;
    logic signed [REQ_Y_W-1:0]    z_ext, y;

    // Every stage moves together, so a stalled output freezes the whole pipe.
    assign adv           = !s3_valid || m_axis_tready;
    assign cfg_load      = (state_q == REQ_IDLE) && cfg_valid;
    assign s_axis_tready = adv && (state_q != REQ_FLUSH) && !cfg_load;
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign m_hs          = s3_valid && m_axis_tready;
    assign cfg_ready     = (state_q == REQ_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ_IDLE: begin
                if (s_hs) begin
                    state_d = s_axis_tlast ? REQ_FLUSH : REQ_RUN;
                end
            end
            REQ_RUN: begin
                if (s_hs && s_axis_tlast) begin
                    state_d = REQ_FLUSH;
                end
            end
            REQ_FLUSH: begin
                if (frame_done) begin
                    state_d = REQ_IDLE;
                end
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    always_comb begin
        mult_d  = mult_q;
        shift_d = shift_q;
        zp_d    = zp_q;
`ifdef NPU_REQUANT_RELU_EN
        relu_d  = relu_q;
`endif
        if (cfg_load) begin
            mult_d  = cfg_multiplier;
            shift_d = (cfg_shift > SHIFT_WIDTH'(REQ_S_MAX)) ? SHIFT_WIDTH'(REQ_S_MAX) : cfg_shift;
            zp_d    = cfg_zero_point;
`ifdef NPU_REQUANT_RELU_EN
            relu_d  = cfg_relu;
`endif
        end
    end

    always_comb begin
        x_ext = {{(REQ_PROD_W-IN_WIDTH){s_axis_tdata[IN_WIDTH-1]}}, s_axis_tdata};
        m_ext = {{(REQ_PROD_W-MULT_WIDTH){mult_q[MULT_WIDTH-1]}}, mult_q};
        prod  = x_ext * m_ext;
        s1_in = {s_axis_tlast, s_axis_tuser, prod};
    end

    // One extra bit keeps p + 2^(S-1) from wrapping when |p| is near 2^46.
    always_comb begin
        s1_last = s1_out[S1_W-1];
        s1_user = s1_out[S1_W-2 -: NCW];
        s1_prod = s1_out[REQ_PROD_W-1:0];
        p_ext   = {s1_prod[REQ_PROD_W-1], s1_prod};
        rnd     = (shift_q == '0) ? '0 : (R_ONE << (shift_q - SHIFT_WIDTH'(1)));
        rsum    = p_ext + rnd;
        rshift  = rsum >>> shift_q;
        s2_in   = {s1_last, s1_user, rshift};
    end

    always_comb begin
        s2_last = s2_out[S2_W-1];
        s2_user = s2_out[S2_W-2 -: NCW];
        s2_r    = s2_out[REQ_R_W-1:0];
        z_ext   = {{(REQ_Y_W-OUT_WIDTH){zp_q[OUT_WIDTH-1]}}, zp_q};
        y       = {s2_r[REQ_R_W-1], s2_r} + z_ext;
`ifdef NPU_REQUANT_RELU_EN
        if (relu_q && (y < z_ext)) begin
            y = z_ext;
        end
`endif
        s3_in = {s2_last, s2_user, OUT_WIDTH'(req_saturate(y))};
    end

    assign m_axis_tvalid = s3_valid;
    assign m_axis_tlast  = s3_out[S3_W-1];
    assign m_axis_tuser  = s3_out[S3_W-2 -: NCW];
    assign m_axis_tdata  = s3_out[OUT_WIDTH-1:0];
    assign frame_done    = m_hs && m_axis_tlast;

    // The final count stays visible for one cycle after tlast, then clears.
    always_comb begin
        count_d     = count_clr_q ? 16'd0 : count_q;
        count_clr_d = frame_done;
        if (m_hs) begin
            count_d = count_d + 16'd1;
        end
    end

    assign beat_count = count_q;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q     <= REQ_IDLE;
            mult_q      <= MULT_WIDTH'(REQ_M_RESET);
            shift_q     <= SHIFT_WIDTH'(REQ_S_RESET);
            zp_q        <= '0;
`ifdef NPU_REQUANT_RELU_EN
            relu_q      <= 1'b0;
`endif
            count_q     <= '0;
            count_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mult_q      <= mult_d;
            shift_q     <= shift_d;
            zp_q        <= zp_d;
`ifdef NPU_REQUANT_RELU_EN
            relu_q      <= relu_d;
`endif
            count_q     <= count_d;
            count_clr_q <= count_clr_d;
        end
    end

    requant_pipe_stage #(.WIDTH(S1_W)) u_stage1 (
        .clk       (s_axis_aclk),
        .rst_n     (s_axis_aresetn),
        .adv       (adv),
        .in_valid  (s_hs),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_data  (s1_out)
    );

    requant_pipe_stage #(.WIDTH(S2_W)) u_stage2 (
        .clk       (s_axis_aclk),
        .rst_n     (s_axis_aresetn),
        .adv       (adv),
        .in_valid  (s1_valid),
        .in_data   (s2_in),
        .out_valid (s2_valid),
        .out_data  (s2_out)
    );

    requant_pipe_stage #(.WIDTH(S3_W)) u_stage3 (
        .clk       (s_axis_aclk),
        .rst_n     (s_axis_aresetn),
        .adv       (adv),
        .in_valid  (s2_valid),
        .in_data   (s3_in),
        .out_valid (s3_valid),
        .out_data  (s3_out)
    );

endmodule

// File: tb/tb_requant_stream.sv
// Directed self-checking bench for requant_stream; expected values are hand-computed.
// Follows NPU_REQUANT_RELU_EN to pick the ReLU or plain-saturation expectation.
module tb_requant_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_multiplier = '0;
    logic [5:0]  cfg_shift = '0;
    logic [7:0]  cfg_zero_point = '0;
`ifdef NPU_REQUANT_RELU_EN
    logic        cfg_relu = 1'b0;
`endif
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [6:0]  s_axis_tuser = '0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic [6:0]  m_axis_tuser;
    logic        frame_done;
    logic [15:0] beat_count;

    int checks = 0;
    int errors = 0;
    int got_data[$];
    int got_last[$];
    int got_user[$];
    int fd_at[$];
    int exp_q[$];
    int user_base = 0;

    requant_stream dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_multiplier (cfg_multiplier),
        .cfg_shift      (cfg_shift),
        .cfg_zero_point (cfg_zero_point),
`ifdef NPU_REQUANT_RELU_EN
        .cfg_relu       (cfg_relu),
`endif
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .frame_done     (frame_done),
        .beat_count     (beat_count)
    );

    always #5 clk = ~clk;

    // Output monitor: records every accepted beat and where frame_done fired.
    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            got_data.push_back(int'($signed(m_axis_tdata)));
            got_last.push_back(int'(m_axis_tlast));
            got_user.push_back(int'(m_axis_tuser));
        end
        if (frame_done) begin
            fd_at.push_back(got_data.size());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyConfig(input logic [31:0] m, input int s, input int z);
        checkOutput("cfg.ready_idle", int'(cfg_ready), 1);
        cfg_multiplier = m;
        cfg_shift      = 6'(s);
        cfg_zero_point = 8'(z);
        cfg_valid      = 1'b1;
        tick();
        cfg_valid      = 1'b0;
    endtask

    task automatic applyStimulus(input int x, input int user, input bit last);
        bit hs;
        int guard;
        hs = 1'b0;
        guard = 0;
        s_axis_tdata  = 16'(x);
        s_axis_tuser  = 7'(user);
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        while (!hs && guard < 100) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            guard++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        checkOutput("in.handshake", int'(hs), 1);
    endtask

    task automatic checkFrame(input string tag);
        int n;
        int guard;
        n = exp_q.size();
        guard = 0;
        while ((got_data.size() < n || !cfg_ready) && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput({tag, ".count"}, got_data.size(), n);
        checkOutput({tag, ".beat_count"}, int'(beat_count), n);
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            checkOutput($sformatf("%s.data%0d", tag, i), got_data[i], exp_q[i]);
            checkOutput($sformatf("%s.last%0d", tag, i), got_last[i], (i == n - 1) ? 1 : 0);
            checkOutput($sformatf("%s.user%0d", tag, i), got_user[i], user_base + i);
        end
        checkOutput({tag, ".fd_pulses"}, fd_at.size(), 1);
        if (fd_at.size() > 0) begin
            checkOutput({tag, ".fd_beat"}, fd_at[0], n);
        end
        tick();
        checkOutput({tag, ".beat_clear"}, int'(beat_count), 0);
        got_data.delete();
        got_last.delete();
        got_user.delete();
        fd_at.delete();
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        checkOutput("rst.m_tvalid", int'(m_axis_tvalid), 0);
        checkOutput("rst.m_tdata", int'(m_axis_tdata), 0);
        checkOutput("rst.m_tlast", int'(m_axis_tlast), 0);
        checkOutput("rst.m_tuser", int'(m_axis_tuser), 0);
        checkOutput("rst.frame_done", int'(frame_done), 0);
        checkOutput("rst.beat_count", int'(beat_count), 0);
        checkOutput("rst.cfg_ready", int'(cfg_ready), 1);
        rst_n = 1'b1;
        tick();

        // Identity config from reset, saturation at both ends
        applyStimulus(100, 1, 0);
        applyStimulus(300, 2, 0);
        applyStimulus(-300, 3, 1);
        exp_q = '{100, 127, -128};
        user_base = 1;
        checkFrame("ident");

        // x0.5 with round half toward +inf
        applyConfig(32'h4000_0000, 31, 0);
        applyStimulus(5, 10, 0);
        applyStimulus(-5, 11, 0);
        applyStimulus(3, 12, 1);
        exp_q = '{3, -2, 2};
        user_base = 10;
        checkFrame("round");

        // Zero point -10, single-beat frame goes straight to FLUSH
`ifdef NPU_REQUANT_RELU_EN
        cfg_relu = 1'b1;
`endif
        applyConfig(32'h4000_0000, 30, -10);
`ifdef NPU_REQUANT_RELU_EN
        cfg_relu = 1'b0;
`endif
        applyStimulus(-20, 20, 1);
        checkOutput("zp.flush_cfg_ready", int'(cfg_ready), 0);
        checkOutput("zp.flush_s_tready", int'(s_axis_tready), 0);
`ifdef NPU_REQUANT_RELU_EN
        exp_q = '{-10};
`else
        exp_q = '{-30};
`endif
        user_base = 20;
        checkFrame("zp");

        // Extreme product with shift 63 clamped to 47 and no rounding overflow
        applyConfig(32'h8000_0000, 63, 0);
        applyStimulus(-32768, 30, 0);
        applyStimulus(32767, 31, 1);
        exp_q = '{1, 0};
        user_base = 30;
        checkFrame("wide");

        // S = 0 passes the product through, then zero point and saturation
        applyConfig(32'h0000_0003, 0, 5);
        applyStimulus(20, 40, 0);
        applyStimulus(-100, 41, 0);
        applyStimulus(40, 42, 0);
        applyStimulus(41, 43, 1);
        exp_q = '{65, -128, 125, 127};
        user_base = 40;
        checkFrame("s0");

        // Eight-beat frame with output stalled for six cycles
        applyConfig(32'h4000_0000, 30, 0);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    applyStimulus(16 * i - 50, 50 + i, i == 7);
                end
            end
            begin
                repeat (4) tick();
                m_axis_tready = 1'b0;
                #1;
                checkOutput("stall.s_tready_low", int'(s_axis_tready), 0);
                checkOutput("stall.m_tvalid", int'(m_axis_tvalid), 1);
                repeat (6) tick();
                checkOutput("stall.held_data", int'($signed(m_axis_tdata)), -34);
                checkOutput("stall.held_user", int'(m_axis_tuser), 51);
                m_axis_tready = 1'b1;
            end
        join
        exp_q = '{-50, -34, -18, -2, 14, 30, 46, 62};
        user_base = 50;
        checkFrame("stall");

        // Config and input together in IDLE: config wins, input waits a cycle
        cfg_multiplier = 32'h4000_0000;
        cfg_shift      = 6'd29;
        cfg_zero_point = 8'd0;
        cfg_valid      = 1'b1;
        s_axis_tdata   = 16'd10;
        s_axis_tuser   = 7'd3;
        s_axis_tvalid  = 1'b1;
        #1;
        checkOutput("coll.s_tready_blocked", int'(s_axis_tready), 0);
        tick();
        cfg_valid = 1'b0;
        #1;
        checkOutput("coll.s_tready_open", int'(s_axis_tready), 1);
        applyStimulus(10, 3, 0);
        // Config request while RUN is ignored
        cfg_multiplier = 32'h0;
        cfg_shift      = 6'd0;
        cfg_zero_point = 8'd7;
        cfg_valid      = 1'b1;
        #1;
        checkOutput("run.cfg_ready", int'(cfg_ready), 0);
        applyStimulus(-20, 4, 1);
        cfg_valid = 1'b0;
        exp_q = '{20, -40};
        user_base = 3;
        checkFrame("runcfg");

        // Asynchronous reset with two beats in flight
        m_axis_tready = 1'b0;
        applyStimulus(7, 0, 0);
        applyStimulus(8, 1, 0);
        tick();
        checkOutput("mrst.pre_tvalid", int'(m_axis_tvalid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst.tvalid_drop", int'(m_axis_tvalid), 0);
        checkOutput("mrst.cfg_ready", int'(cfg_ready), 1);
        tick();
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        checkOutput("mrst.post_tvalid", int'(m_axis_tvalid), 0);
        checkOutput("mrst.post_cfg_ready", int'(cfg_ready), 1);
        applyStimulus(50, 9, 1);
        exp_q = '{50};
        user_base = 9;
        checkFrame("mrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
